// File: rtl/intra_pred_nxn_if.sv
// intra_pred_nxn_if: block-level bus of the NxN intra predictor.
// master = pixel source / residual sink side, slave = the predictor itself.
interface intra_pred_nxn_if #(
  parameter int BLK      = 4,
  parameter int BITDEPTH = 8
);
  localparam int SADW = BITDEPTH + 2 * $clog2(BLK);

  logic                        NEWBLK;
  logic [BLK*BITDEPTH-1:0]     TOPI;
  logic [BLK*BITDEPTH-1:0]     LEFTI;
  logic                        TOPVALID;
  logic                        LEFTVALID;
  logic                        STROBEI;
  logic [4*BITDEPTH-1:0]       DATAI;
  logic                        READYI;
  logic                        READYO;
  logic                        STROBEO;
  logic [4*(BITDEPTH+1)-1:0]   DATAO;
  logic                        LASTO;
  logic                        MSTROBEO;
  logic [1:0]                  MODEO;
  logic [SADW-1:0]             SADO;

  modport master (
    output NEWBLK, TOPI, LEFTI, TOPVALID, LEFTVALID, STROBEI, DATAI, READYO,
    input  READYI, STROBEO, DATAO, LASTO, MSTROBEO, MODEO, SADO
  );

  modport slave (
    input  NEWBLK, TOPI, LEFTI, TOPVALID, LEFTVALID, STROBEI, DATAI, READYO,
    output READYI, STROBEO, DATAO, LASTO, MSTROBEO, MODEO, SADO
  );
endinterface

// File: rtl/intra_pred_nxn.sv
// intra_pred_nxn: NxN (4 or 8) luma intra predictor and mode selector.
// Latches neighbours, accumulates V/H/DC SADs while buffering the block,
// picks the cheapest available mode and streams signed residuals.
// Optional macro INTRA_NXN_MODE_BIAS_EN: adds MODE_BIAS to the V and H costs.
module intra_pred_nxn #(
  parameter int BLK       = 4,
  parameter int BITDEPTH  = 8,
  parameter int MODE_BIAS = 4
) (
  input  logic            CLK,
  input  logic            RESETN,
  intra_pred_nxn_if.slave bus
);
  localparam int LB    = $clog2(BLK);
  localparam int NBEAT = BLK * BLK / 4;
  localparam int KW    = $clog2(NBEAT);
  localparam int QPR   = BLK / 4;            // input beats per pixel row
  localparam int SADW  = BITDEPTH + 2 * LB;
  localparam int CW    = SADW + 1;           // cost width with headroom for the bias
  localparam int SUMW  = BITDEPTH + LB + 1;  // top+left sums plus rounding term
  localparam int RW    = BITDEPTH + 1;
  localparam int BW    = BITDEPTH + 2;       // one beat's four absolute differences
`ifdef INTRA_NXN_MODE_BIAS_EN
  localparam int BIAS  = MODE_BIAS;
`else
  // Bias disabled: raw SADs are compared, MODE_BIAS has no effect.
  localparam int BIAS  = MODE_BIAS * 0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_LOAD, S_DECIDE, S_EMIT} state_t;
  state_t r_state, w_state_next;

  logic [BLK*BITDEPTH-1:0] r_top, r_left;
  logic                    r_topv, r_leftv;
  logic [BITDEPTH-1:0]     r_dc;
  logic [SADW-1:0]         r_sad_v, r_sad_h, r_sad_d;
  logic [KW-1:0]           r_cnt;
  logic [1:0]              r_mode;
  logic [SADW-1:0]         r_sad;
  logic                    r_mstrobe, r_strobeo, r_lasto;
  logic [4*RW-1:0]         r_datao;
  logic [4*BITDEPTH-1:0]   r_buf [NBEAT];

  logic                    w_accept, w_emit, w_last_cnt;
  logic [LB-1:0]           w_row;
  logic [4*BITDEPTH-1:0]   w_buf_word;
  logic [BITDEPTH-1:0]     w_dv [4];
  logic [BITDEPTH-1:0]     w_dh [4];
  logic [BITDEPTH-1:0]     w_dd [4];
  logic [4*RW-1:0]         w_res;
  logic [BW-1:0]           w_beat_v, w_beat_h, w_beat_d;
  logic [SUMW-1:0]         w_sum_top, w_sum_left;
  logic [BITDEPTH-1:0]     w_dc_next;
  logic [CW-1:0]           w_cost_v, w_cost_h, w_cost_d, w_best_cost;
  logic [1:0]              w_best_mode;

  function automatic logic [BITDEPTH-1:0] absdiff(input logic [BITDEPTH-1:0] a,
                                                  input logic [BITDEPTH-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  assign w_accept   = (r_state == S_LOAD) && bus.STROBEI;
  assign w_emit     = (r_state == S_EMIT) && bus.READYO && !r_lasto;
  assign w_last_cnt = (r_cnt == KW'(NBEAT - 1));
  // The same counter walks the block in raster order during LOAD and EMIT.
  assign w_row      = LB'(int'(r_cnt) / QPR);
  assign w_buf_word = r_buf[r_cnt];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [LB-1:0]       w_col;
      logic [BITDEPTH-1:0] w_in_px, w_buf_px, w_top_px, w_left_px, w_pred_px;
      assign w_col     = LB'((int'(r_cnt) % QPR) * 4 + gi);
      assign w_in_px   = bus.DATAI[gi*BITDEPTH +: BITDEPTH];
      assign w_buf_px  = w_buf_word[gi*BITDEPTH +: BITDEPTH];
      assign w_top_px  = r_top[w_col*BITDEPTH +: BITDEPTH];
      assign w_left_px = r_left[w_row*BITDEPTH +: BITDEPTH];
      assign w_dv[gi]  = absdiff(w_in_px, w_top_px);
      assign w_dh[gi]  = absdiff(w_in_px, w_left_px);
      assign w_dd[gi]  = absdiff(w_in_px, r_dc);
      assign w_pred_px = (r_mode == 2'd0) ? w_top_px :
                         (r_mode == 2'd1) ? w_left_px : r_dc;
      assign w_res[gi*RW +: RW] = {1'b0, w_buf_px} - {1'b0, w_pred_px};
    end
  endgenerate

  // Per-beat cost contributions of the three predictors.
  always_comb begin
    w_beat_v = '0;
    w_beat_h = '0;
    w_beat_d = '0;
    for (int i = 0; i < 4; i++) begin
      w_beat_v = w_beat_v + BW'(w_dv[i]);
      w_beat_h = w_beat_h + BW'(w_dh[i]);
      w_beat_d = w_beat_d + BW'(w_dd[i]);
    end
  end

  // DC prediction from whichever neighbours are available, rounded.
  always_comb begin
    w_sum_top  = '0;
    w_sum_left = '0;
    for (int i = 0; i < BLK; i++) begin
      w_sum_top  = w_sum_top  + SUMW'(r_top[i*BITDEPTH +: BITDEPTH]);
      w_sum_left = w_sum_left + SUMW'(r_left[i*BITDEPTH +: BITDEPTH]);
    end
    if (r_topv && r_leftv)
      w_dc_next = BITDEPTH'((w_sum_top + w_sum_left + SUMW'(BLK)) >> (LB + 1));
    else if (r_topv)
      w_dc_next = BITDEPTH'((w_sum_top + SUMW'(BLK / 2)) >> LB);
    else if (r_leftv)
      w_dc_next = BITDEPTH'((w_sum_left + SUMW'(BLK / 2)) >> LB);
    else
      w_dc_next = BITDEPTH'(1 << (BITDEPTH - 1));
  end

  // Mode choice: DC is always a candidate; checking H then V with <= lets
  // the lower mode number win every tie.
  always_comb begin
    w_cost_v    = CW'(r_sad_v) + CW'(BIAS);
    w_cost_h    = CW'(r_sad_h) + CW'(BIAS);
    w_cost_d    = CW'(r_sad_d);
    w_best_cost = w_cost_d;
    w_best_mode = 2'd2;
    if (r_leftv && (w_cost_h <= w_best_cost)) begin
      w_best_cost = w_cost_h;
      w_best_mode = 2'd1;
    end
    if (r_topv && (w_cost_v <= w_best_cost)) begin
      w_best_cost = w_cost_v;
      w_best_mode = 2'd0;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic; EMIT leaves only after the last beat has been shown.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.NEWBLK) w_state_next = S_PREP;
      S_PREP:   w_state_next = S_LOAD;
      S_LOAD:   if (w_accept && w_last_cnt) w_state_next = S_DECIDE;
      S_DECIDE: w_state_next = S_EMIT;
      S_EMIT:   if (r_lasto) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Datapath: neighbour capture, DC, SAD accumulation, decision and residual output.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_top     <= '0;
      r_left    <= '0;
      r_topv    <= 1'b0;
      r_leftv   <= 1'b0;
      r_dc      <= '0;
      r_sad_v   <= '0;
      r_sad_h   <= '0;
      r_sad_d   <= '0;
      r_cnt     <= '0;
      r_mode    <= 2'd2;
      r_sad     <= '0;
      r_mstrobe <= 1'b0;
      r_strobeo <= 1'b0;
      r_lasto   <= 1'b0;
      r_datao   <= '0;
    end else begin
      r_mstrobe <= 1'b0;
      r_strobeo <= 1'b0;
      r_lasto   <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.NEWBLK) begin
          r_top   <= bus.TOPI;
          r_left  <= bus.LEFTI;
          r_topv  <= bus.TOPVALID;
          r_leftv <= bus.LEFTVALID;
          r_sad_v <= '0;
          r_sad_h <= '0;
          r_sad_d <= '0;
          r_cnt   <= '0;
        end
        S_PREP: r_dc <= w_dc_next;
        S_LOAD: if (w_accept) begin
          r_sad_v <= r_sad_v + SADW'(w_beat_v);
          r_sad_h <= r_sad_h + SADW'(w_beat_h);
          r_sad_d <= r_sad_d + SADW'(w_beat_d);
          r_cnt   <= r_cnt + 1'b1;
        end
        S_DECIDE: begin
          r_mode    <= w_best_mode;
          r_sad     <= SADW'(w_best_cost);
          r_mstrobe <= 1'b1;
          r_cnt     <= '0;
        end
        S_EMIT: if (w_emit) begin
          r_datao   <= w_res;
          r_strobeo <= 1'b1;
          r_lasto   <= w_last_cnt;
          r_cnt     <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Original-pixel buffer; contents only matter once a full block is loaded.
  always_ff @(posedge CLK) begin
    if (w_accept) r_buf[r_cnt] <= bus.DATAI;
  end

  assign bus.READYI   = (r_state == S_LOAD);
  assign bus.STROBEO  = r_strobeo;
  assign bus.DATAO    = r_datao;
  assign bus.LASTO    = r_lasto;
  assign bus.MSTROBEO = r_mstrobe;
  assign bus.MODEO    = r_mode;
  assign bus.SADO     = r_sad;
endmodule

// File: tb/tb_intra_pred_nxn.sv
// tb_intra_pred_nxn: drives a BLK=4 and a BLK=8 instance from shared stimulus,
// checks table vectors, a reset-mid-load sequence and random blocks.
module tb_intra_pred_nxn;
  localparam int BD = 8;
`ifdef INTRA_NXN_MODE_BIAS_EN
  localparam int TB_BIAS = 4;
`else
  localparam int TB_BIAS = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int sel = 0;

  logic        tb_newblk = 1'b0, tb_strobei = 1'b0, tb_readyo = 1'b0;
  logic        tb_tv = 1'b0, tb_lv = 1'b0;
  logic [63:0] tb_top = '0, tb_left = '0;
  logic [31:0] tb_datai = '0;

  intra_pred_nxn_if #(.BLK(4), .BITDEPTH(BD)) bus4 ();
  intra_pred_nxn_if #(.BLK(8), .BITDEPTH(BD)) bus8 ();

  intra_pred_nxn #(.BLK(4), .BITDEPTH(BD), .MODE_BIAS(4)) u_dut4 (.CLK(clk), .RESETN(rst_n), .bus(bus4));
  intra_pred_nxn #(.BLK(8), .BITDEPTH(BD), .MODE_BIAS(4)) u_dut8 (.CLK(clk), .RESETN(rst_n), .bus(bus8));

  assign bus4.NEWBLK    = tb_newblk & (sel == 0);
  assign bus4.TOPI      = tb_top[31:0];
  assign bus4.LEFTI     = tb_left[31:0];
  assign bus4.TOPVALID  = tb_tv;
  assign bus4.LEFTVALID = tb_lv;
  assign bus4.STROBEI   = tb_strobei & (sel == 0);
  assign bus4.DATAI     = tb_datai;
  assign bus4.READYO    = tb_readyo & (sel == 0);
  assign bus8.NEWBLK    = tb_newblk & (sel == 1);
  assign bus8.TOPI      = tb_top;
  assign bus8.LEFTI     = tb_left;
  assign bus8.TOPVALID  = tb_tv;
  assign bus8.LEFTVALID = tb_lv;
  assign bus8.STROBEI   = tb_strobei & (sel == 1);
  assign bus8.DATAI     = tb_datai;
  assign bus8.READYO    = tb_readyo & (sel == 1);

  logic        o_readyi, o_strobeo, o_lasto, o_mstrobeo;
  logic [1:0]  o_modeo;
  logic [13:0] o_sado;
  logic [35:0] o_datao;
  assign o_readyi   = (sel == 0) ? bus4.READYI   : bus8.READYI;
  assign o_strobeo  = (sel == 0) ? bus4.STROBEO  : bus8.STROBEO;
  assign o_lasto    = (sel == 0) ? bus4.LASTO    : bus8.LASTO;
  assign o_mstrobeo = (sel == 0) ? bus4.MSTROBEO : bus8.MSTROBEO;
  assign o_modeo    = (sel == 0) ? bus4.MODEO    : bus8.MODEO;
  assign o_sado     = (sel == 0) ? {2'b00, bus4.SADO} : bus8.SADO;
  assign o_datao    = (sel == 0) ? bus4.DATAO    : bus8.DATAO;

  // Current block description and results
  int cur_blk;
  int cur_top[8];
  int cur_left[8];
  int cur_orig[64];
  bit cur_tv, cur_lv;
  int exp_mode, exp_sad;
  int exp_res[64];
  int got_mode, got_sad, got_beats;
  int got_res[64];

  typedef struct {
    int blk; int top_v; int left_v; bit tv; bit lv; int data_v;
    int stall; bit nb_emit; int exp_mode; int exp_sad; int exp_res;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Reference: prediction, costs and residuals straight from the pixel rules.
  function automatic void model();
    int st, sl, dc, pred;
    int cost[3];
    bit avail[3];
    st = 0; sl = 0;
    for (int i = 0; i < cur_blk; i++) begin st += cur_top[i]; sl += cur_left[i]; end
    if (cur_tv && cur_lv) dc = (st + sl + cur_blk) / (2 * cur_blk);
    else if (cur_tv)      dc = (st + cur_blk / 2) / cur_blk;
    else if (cur_lv)      dc = (sl + cur_blk / 2) / cur_blk;
    else                  dc = 1 << (BD - 1);
    cost[0] = TB_BIAS; cost[1] = TB_BIAS; cost[2] = 0;
    for (int r = 0; r < cur_blk; r++)
      for (int c = 0; c < cur_blk; c++) begin
        cost[0] += iabs(cur_orig[r*cur_blk+c] - cur_top[c]);
        cost[1] += iabs(cur_orig[r*cur_blk+c] - cur_left[r]);
        cost[2] += iabs(cur_orig[r*cur_blk+c] - dc);
      end
    avail[0] = cur_tv; avail[1] = cur_lv; avail[2] = 1'b1;
    exp_mode = -1; exp_sad = 0;
    for (int m = 0; m < 3; m++)
      if (avail[m] && (exp_mode < 0 || cost[m] < exp_sad)) begin exp_mode = m; exp_sad = cost[m]; end
    for (int r = 0; r < cur_blk; r++)
      for (int c = 0; c < cur_blk; c++) begin
        pred = (exp_mode == 0) ? cur_top[c] : (exp_mode == 1) ? cur_left[r] : dc;
        exp_res[r*cur_blk+c] = cur_orig[r*cur_blk+c] - pred;
      end
  endfunction

  // Drive one block through the DUT selected by cur_blk and collect its outputs.
  // stall: 0 READYO always 1, 1 toggling, 2 random. abort_after>=0 stops loading early.
  task automatic run_block(input int stall, input bit nb_emit, input int abort_after);
    int nbeat, issued, cyc;
    bit exp_strobe;
    logic [35:0] last_datao;
    logic [8:0] px;
    nbeat = cur_blk * cur_blk / 4;
    got_beats = 0; got_mode = -1; got_sad = -1;
    @(negedge clk);
    sel = (cur_blk == 8) ? 1 : 0;
    tb_top = '0; tb_left = '0;
    for (int i = 0; i < cur_blk; i++) begin
      tb_top[i*8 +: 8]  = 8'(cur_top[i]);
      tb_left[i*8 +: 8] = 8'(cur_left[i]);
    end
    tb_tv = cur_tv; tb_lv = cur_lv; tb_newblk = 1'b1;
    @(negedge clk);
    tb_newblk = 1'b0;
    chk("readyi_prep", o_readyi, 0);
    @(negedge clk);
    chk("readyi_load", o_readyi, 1);
    for (int k = 0; k < nbeat; k++) begin
      if (abort_after == k) return;
      if ($urandom_range(0, 3) == 0) begin
        tb_strobei = 1'b0; tb_datai = $urandom;
        @(negedge clk);
      end
      tb_strobei = 1'b1;
      for (int l = 0; l < 4; l++) tb_datai[l*8 +: 8] = 8'(cur_orig[4*k+l]);
      @(negedge clk);
    end
    // Cycle after the last accepted beat: a late strobe must be dropped.
    chk("readyi_drop", o_readyi, 0);
    chk("mstrobe_early", o_mstrobeo, 0);
    tb_strobei = 1'b1; tb_datai = $urandom;
    @(negedge clk);
    tb_strobei = 1'b0;
    issued = 0; exp_strobe = 1'b0; last_datao = '0;
    for (cyc = 0; cyc < 300 && got_beats < nbeat; cyc++) begin
      chk("mstrobeo", o_mstrobeo, (cyc == 0) ? 1 : 0);
      if (cyc == 0) begin got_mode = int'(o_modeo); got_sad = int'(o_sado); end
      chk("strobeo", o_strobeo, exp_strobe);
      if (o_strobeo) begin
        for (int l = 0; l < 4; l++) begin
          px = o_datao[l*9 +: 9];
          if (got_beats < nbeat) got_res[4*got_beats+l] = int'($signed(px));
        end
        chk("lasto", o_lasto, (got_beats == nbeat - 1) ? 1 : 0);
        last_datao = o_datao;
        got_beats++;
      end else if (got_beats > 0) begin
        chk("datao_hold", longint'(o_datao), longint'(last_datao));
      end
      case (stall)
        0:       tb_readyo = 1'b1;
        1:       tb_readyo = (cyc % 2 == 0);
        default: tb_readyo = 1'($urandom_range(0, 1));
      endcase
      tb_newblk = nb_emit && (cyc == 2);
      exp_strobe = tb_readyo && (issued < nbeat);
      if (exp_strobe) issued++;
      @(negedge clk);
    end
    tb_newblk = 1'b0; tb_readyo = 1'b1;
    chk("beat_count", got_beats, nbeat);
    for (int i = 0; i < 2; i++) begin
      chk("post_strobeo", o_strobeo, 0);
      chk("post_readyi", o_readyi, 0);
      @(negedge clk);
    end
    tb_readyo = 1'b0;
    $display("block blk=%0d tv=%0d lv=%0d mode=%0d sad=%0d beats=%0d", cur_blk, cur_tv, cur_lv,
             got_mode, got_sad, got_beats);
  endtask

  task automatic compare_model();
    model();
    chk("mode", got_mode, exp_mode);
    chk("sad", got_sad, exp_sad);
    for (int i = 0; i < cur_blk * cur_blk; i++) chk("residual", got_res[i], exp_res[i]);
  endtask

  initial begin
    int kind;
    vt[0] = '{4, 100, 50, 1'b1, 1'b1, 100, 0, 1'b0, 0, TB_BIAS, 0};
    vt[1] = '{4, 77, 33, 1'b0, 1'b0, 120, 2, 1'b0, 2, 128, -8};
    vt[2] = '{4, 80, 80, 1'b1, 1'b1, 80, 1, 1'b1, (TB_BIAS > 0) ? 2 : 0, 0, 0};
    vt[3] = '{8, -1, -2, 1'b1, 1'b1, -1, 2, 1'b0, 1, TB_BIAS, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_readyi", o_readyi, 0);
    chk("rst_modeo", o_modeo, 2);
    chk("rst_sado", o_sado, 0);
    chk("rst_strobeo", o_strobeo, 0);
    chk("rst_mstrobeo", o_mstrobeo, 0);
    rst_n = 1'b1;

    // Table vectors with fixed expectations
    for (int v = 0; v < 4; v++) begin
      cur_blk = vt[v].blk; cur_tv = vt[v].tv; cur_lv = vt[v].lv;
      for (int i = 0; i < 8; i++) begin
        cur_top[i]  = (vt[v].top_v < 0) ? int'($urandom_range(0, 255)) : vt[v].top_v;
        cur_left[i] = (vt[v].left_v == -2) ? i * 30 + 5 : vt[v].left_v;
      end
      for (int r = 0; r < cur_blk; r++)
        for (int c = 0; c < cur_blk; c++)
          cur_orig[r*cur_blk+c] = (vt[v].data_v < 0) ? cur_left[r] : vt[v].data_v;
      run_block(vt[v].stall, vt[v].nb_emit, -1);
      chk("tbl_mode", got_mode, vt[v].exp_mode);
      chk("tbl_sad", got_sad, vt[v].exp_sad);
      for (int i = 0; i < cur_blk * cur_blk; i++) chk("tbl_residual", got_res[i], vt[v].exp_res);
    end

    // Reset in the middle of LOAD, then a fresh block on the same instance
    cur_blk = 8; cur_tv = 1'b1; cur_lv = 1'b1;
    for (int i = 0; i < 8; i++) begin cur_top[i] = $urandom_range(0, 255); cur_left[i] = $urandom_range(0, 255); end
    for (int i = 0; i < 64; i++) cur_orig[i] = $urandom_range(0, 255);
    run_block(0, 1'b0, 5);
    tb_strobei = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_readyi", o_readyi, 0);
    chk("mid_rst_modeo", o_modeo, 2);
    chk("mid_rst_sado", o_sado, 0);
    chk("mid_rst_datao", longint'(o_datao), 0);
    chk("mid_rst_lasto", o_lasto, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) cur_orig[i] = cur_top[i % 8] ^ int'($urandom_range(0, 7));
    run_block(1, 1'b0, -1);
    compare_model();

    // Random blocks against the reference model
    for (int t = 0; t < 20; t++) begin
      cur_blk = ($urandom_range(0, 1) == 1) ? 8 : 4;
      cur_tv = 1'($urandom_range(0, 1));
      cur_lv = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 2);
      for (int i = 0; i < 8; i++) begin cur_top[i] = $urandom_range(0, 255); cur_left[i] = $urandom_range(0, 255); end
      for (int r = 0; r < cur_blk; r++)
        for (int c = 0; c < cur_blk; c++)
          case (kind)
            0:       cur_orig[r*cur_blk+c] = $urandom_range(0, 255);
            1:       cur_orig[r*cur_blk+c] = cur_top[c] ^ int'($urandom_range(0, 3));
            default: cur_orig[r*cur_blk+c] = cur_left[r] ^ int'($urandom_range(0, 3));
          endcase
      run_block(t % 3, (t % 4) == 1, -1);
      compare_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
